fe_bu_res_rx: RTL and testbench
===============================

// Module: fe_bu_res_rx
// PURPOSE
// - Frontend-side receiver for branch resolutions issued by the execution-stage branch unit.
// - Buffers BPU training updates, which arrive as single-cycle pulses with no backpressure, in a small FIFO.
// - Turns a misprediction notification into a PC-generator redirect and acknowledges the branch unit with a ready handshake.
// - Sits between the branch unit and the frontend's bpu/pc_gen blocks.
// PARAMETERS
// - XLEN            64  width of PCs and targets
// - BPU_FIFO_DEPTH   4  BPU update FIFO entries; power of 2, >=2
// PORTS
// - clk_i                   in   1     clock
// - rst_i                   in   1     reset, synchronous, active-high
// - flush_i                 in   1     pipeline flush
// - bu_bpu_valid_i          in   1     resolution pulse; no ready exists
// - bu_res_pc_i             in   XLEN  PC of the resolved branch
// - bu_res_target_i         in   XLEN  computed taken target
// - bu_res_taken_i          in   1     actual branch outcome
// - bu_pcgen_valid_i        in   1     redirect request; held until acknowledged
// - bu_pcgen_ready_o        out  1     redirect acknowledge to the branch unit
// - bpu_upd_valid_o         out  1     FIFO head valid
// - bpu_upd_ready_i         in   1     BPU consumes the head
// - bpu_upd_pc_o            out  XLEN  head PC
// - bpu_upd_target_o        out  XLEN  head target
// - bpu_upd_taken_o         out  1     head outcome
// - pcgen_redirect_valid_o  out  1     redirect request to pc_gen
// - pcgen_redirect_ready_i  in   1     pc_gen accepts the redirect
// - pcgen_redirect_pc_o     out  XLEN  redirect PC
// - res_overflow_o          out  1     sticky flag: an update was dropped on a full FIFO
// BEHAVIOUR
// - Reset:
//   - FIFO empty; FSM in R_IDLE.
//   - All valid/ready outputs are 0, res_overflow_o is 0, data outputs are 0.
// - FIFO write: on bu_bpu_valid_i, entry {pc, target, taken}.
//   - A write while full is accepted only if the head is popped in the same cycle.
//   - Otherwise the write is dropped and res_overflow_o is set; it clears only on rst_i.
// - FIFO read: pop when bpu_upd_valid_o && bpu_upd_ready_i.
//   - Pointers wrap modulo BPU_FIFO_DEPTH.
//   - The count register is clog2(DEPTH)+1 bits wide.
//   - A write reaches the output one cycle after it is accepted (registered).
// - flush_i does NOT clear the FIFO: committed-path training is kept. The FSM returns to R_IDLE.
// - Redirect PC is computed on the cycle the request is captured:
//   - taken: bu_res_target_i
//   - not taken: bu_res_pc_i + 4
//   - The add wraps modulo 2^XLEN.
//   - The value is registered and stable while pcgen_redirect_valid_o is high.
// - FSM:
//   - R_IDLE: when bu_pcgen_valid_i, capture the redirect PC and go to R_REQ.
//   - R_REQ: pcgen_redirect_valid_o=1. When pcgen_redirect_ready_i, go to R_ACK; otherwise stay. Valid is never dropped before ready.
//   - R_ACK: bu_pcgen_ready_o=1 for exactly one cycle, then R_WAIT.
//   - R_WAIT: wait for !bu_pcgen_valid_i, then R_IDLE. This prevents a stale held request from re-triggering.
//   - Latency from request to pc_gen valid is 1 cycle. Ack comes 1 cycle after pc_gen accepts.
// - Simultaneous events:
//   - flush_i beats every FSM transition. In R_REQ, a flush cancels the redirect (valid goes to 0 next cycle).
//   - rst_i beats flush_i.
//   - bu_bpu_valid_i and bu_pcgen_valid_i in the same cycle are both serviced independently.
// CONFIGURATION
// - LEN5_FE_RES_BYPASS_EN defined:
//   - When the FIFO is empty and bpu_upd_ready_i=1, an incoming update is driven combinationally to the bpu_upd_* outputs in the same cycle and is not written.
//   - When the FIFO is empty and bpu_upd_ready_i=0, the update is written as usual.
// - LEN5_FE_RES_BYPASS_EN undefined: every update goes through the FIFO (1-cycle latency).
// STRUCTURE
// - len5_pkg gets `bpu_upd_t` {pc, target, taken} and the `BPU_RES_FIFO_DEPTH` default constant.
// - The FSM state enum (R_IDLE, R_REQ, R_ACK, R_WAIT) stays local.
// - Sub-module: fe_res_fifo, a parameterised sync FIFO of bpu_upd_t with full/empty/count and a push-while-full-with-pop rule.
// - Top level: redirect FSM, redirect-PC register and adder, overflow flag, optional bypass mux.
// TESTING
// - Update pass-through: pulse {pc=0x1000, tgt=0x2000, taken=1} with bpu_upd_ready_i=1 -> head appears next cycle (same cycle with BYPASS_EN); popped; FIFO empty.
// - Overflow: ready=0, 5 pulses with DEPTH=4 -> 4 entries held, res_overflow_o=1 after the 5th. Drain -> PCs come out in order; flag stays 1.
// - Full push+pop: FIFO full, ready=1 and a pulse in the same cycle -> no overflow, count stays 4.
// - Redirect not taken: pc=0x8000_0000, taken=0, pc_gen ready held 0 for 3 cycles -> redirect_pc=0x8000_0004 stable with valid high; one-cycle bu_pcgen_ready_o after accept.
// - Wrap-around: pc=0xFFFF_FFFF_FFFF_FFFC, taken=0 -> redirect_pc=0x0.
// - Flush in R_REQ: flush_i asserted -> pcgen_redirect_valid_o=0 next cycle, no ack, FIFO contents unchanged.

Source files
------------

// File: rtl/len5_pkg.sv
// len5_pkg: shared frontend types and defaults for branch-resolution handling
package len5_pkg;
  localparam int XLEN = 64;
  localparam int BPU_RES_FIFO_DEPTH = 4;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] target;
    logic            taken;
  } bpu_upd_t;
endpackage

// File: rtl/fe_res_fifo.sv
// fe_res_fifo: sync FIFO of BPU updates; a push while full is taken only alongside a pop
module fe_res_fifo import len5_pkg::*; #(
  parameter int DEPTH = BPU_RES_FIFO_DEPTH
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  bpu_upd_t                 data_i,
  input  logic                     pop_i,
  output bpu_upd_t                 data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  bpu_upd_t       mem [DEPTH];
  logic [AW-1:0]  wr_q, rd_q;
  logic [AW:0]    cnt_q;
  logic           do_push, do_pop;
  assign empty_o = cnt_q == '0;
  assign full_o  = cnt_q == (AW+1)'(DEPTH);
  assign count_o = cnt_q;
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem[rd_q];
  // pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end
  // storage needs no reset; outputs are gated by emptiness upstream
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_q] <= data_i;
  end
endmodule

// File: rtl/fe_bu_res_rx.sv
// fe_bu_res_rx: buffers branch-unit BPU updates and turns mispredictions into pc_gen redirects (optional LEN5_FE_RES_BYPASS_EN)
module fe_bu_res_rx import len5_pkg::*; #(
  parameter int BPU_FIFO_DEPTH = BPU_RES_FIFO_DEPTH
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            bu_bpu_valid_i,
  input  logic [XLEN-1:0] bu_res_pc_i,
  input  logic [XLEN-1:0] bu_res_target_i,
  input  logic            bu_res_taken_i,
  input  logic            bu_pcgen_valid_i,
  output logic            bu_pcgen_ready_o,
  output logic            bpu_upd_valid_o,
  input  logic            bpu_upd_ready_i,
  output logic [XLEN-1:0] bpu_upd_pc_o,
  output logic [XLEN-1:0] bpu_upd_target_o,
  output logic            bpu_upd_taken_o,
  output logic            pcgen_redirect_valid_o,
  input  logic            pcgen_redirect_ready_i,
  output logic [XLEN-1:0] pcgen_redirect_pc_o,
  output logic            res_overflow_o
);
  typedef enum logic [1:0] {R_IDLE, R_REQ, R_ACK, R_WAIT} r_state_t;
  r_state_t                        state_q, state_d;
  bpu_upd_t                        upd_in, head, upd_out;
  logic                            byp, push, full, empty;
  logic [$clog2(BPU_FIFO_DEPTH):0] count;
  logic [XLEN-1:0]                 redir_q;
  logic                            ovf_q;
  assign upd_in = '{pc: bu_res_pc_i, target: bu_res_target_i, taken: bu_res_taken_i};
`ifdef LEN5_FE_RES_BYPASS_EN
  assign byp = empty && bpu_upd_ready_i && bu_bpu_valid_i;
`else
  assign byp = 1'b0;
`endif
  assign push = bu_bpu_valid_i && !byp;
  fe_res_fifo #(.DEPTH(BPU_FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (upd_in),
    .pop_i   (bpu_upd_ready_i),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );
  assign upd_out          = !empty ? head : byp ? upd_in : '0;
  assign bpu_upd_valid_o  = (count != '0) || byp;
  assign bpu_upd_pc_o     = upd_out.pc;
  assign bpu_upd_target_o = upd_out.target;
  assign bpu_upd_taken_o  = upd_out.taken;
  assign res_overflow_o   = ovf_q;
  assign pcgen_redirect_pc_o = redir_q;
  // sticky drop flag: a full FIFO only makes room when the head leaves this cycle
  always_ff @(posedge clk_i) begin
    if (rst_i) ovf_q <= 1'b0;
    else if (push && full && !bpu_upd_ready_i) ovf_q <= 1'b1;
  end
  // redirect state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= R_IDLE;
    else state_q <= state_d;
  end
  // next state and handshake outputs; flush overrides every transition
  always_comb begin
    state_d = flush_i ? R_IDLE :
              (state_q == R_IDLE && bu_pcgen_valid_i) ? R_REQ :
              (state_q == R_REQ && pcgen_redirect_ready_i) ? R_ACK :
              (state_q == R_ACK) ? R_WAIT :
              (state_q == R_WAIT && !bu_pcgen_valid_i) ? R_IDLE : state_q;
    pcgen_redirect_valid_o = state_q == R_REQ;
    bu_pcgen_ready_o       = state_q == R_ACK;
  end
  // redirect PC captured with the request so it stays stable while valid is high
  always_ff @(posedge clk_i) begin
    if (rst_i) redir_q <= '0;
    else if (state_q == R_IDLE && bu_pcgen_valid_i && !flush_i)
      redir_q <= bu_res_taken_i ? bu_res_target_i : bu_res_pc_i + XLEN'(4);
  end
endmodule

// File: tb/tb_fe_bu_res_rx.sv
// tb_fe_bu_res_rx: randomized self-checking bench with a queue-based reference model
module tb_fe_bu_res_rx;
  import len5_pkg::*;
  localparam int D = BPU_RES_FIFO_DEPTH;
`ifdef LEN5_FE_RES_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic            clk = 1'b0;
  logic            rst_i, flush_i, bu_bpu_valid_i, bu_res_taken_i, bu_pcgen_valid_i;
  logic [XLEN-1:0] bu_res_pc_i, bu_res_target_i;
  logic            bu_pcgen_ready_o, bpu_upd_valid_o, bpu_upd_ready_i, bpu_upd_taken_o;
  logic [XLEN-1:0] bpu_upd_pc_o, bpu_upd_target_o, pcgen_redirect_pc_o;
  logic            pcgen_redirect_valid_o, pcgen_redirect_ready_i, res_overflow_o;
  int              n_chk = 0;
  int              n_fail = 0;
  bpu_upd_t        q[$];
  logic            ovf_m;

  always #5 clk = ~clk;

  fe_bu_res_rx dut (
    .clk_i                  (clk),
    .rst_i                  (rst_i),
    .flush_i                (flush_i),
    .bu_bpu_valid_i         (bu_bpu_valid_i),
    .bu_res_pc_i            (bu_res_pc_i),
    .bu_res_target_i        (bu_res_target_i),
    .bu_res_taken_i         (bu_res_taken_i),
    .bu_pcgen_valid_i       (bu_pcgen_valid_i),
    .bu_pcgen_ready_o       (bu_pcgen_ready_o),
    .bpu_upd_valid_o        (bpu_upd_valid_o),
    .bpu_upd_ready_i        (bpu_upd_ready_i),
    .bpu_upd_pc_o           (bpu_upd_pc_o),
    .bpu_upd_target_o       (bpu_upd_target_o),
    .bpu_upd_taken_o        (bpu_upd_taken_o),
    .pcgen_redirect_valid_o (pcgen_redirect_valid_o),
    .pcgen_redirect_ready_i (pcgen_redirect_ready_i),
    .pcgen_redirect_pc_o    (pcgen_redirect_pc_o),
    .res_overflow_o         (res_overflow_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // compare FIFO-side outputs against the model, then advance one clock
  task automatic step();
    bpu_upd_t e;
    logic     ev, byp, full, popped;
    #1;
    ev = q.size() > 0 || (BYP && bu_bpu_valid_i && bpu_upd_ready_i);
    e.pc = bu_res_pc_i;
    e.target = bu_res_target_i;
    e.taken = bu_res_taken_i;
    if (q.size() > 0) e = q[0];
    else if (!ev) e = '0;
    chk("upd_valid", 64'(bpu_upd_valid_o), 64'(ev));
    chk("upd_pc", bpu_upd_pc_o, e.pc);
    chk("upd_target", bpu_upd_target_o, e.target);
    chk("upd_taken", 64'(bpu_upd_taken_o), 64'(e.taken));
    chk("overflow", 64'(res_overflow_o), 64'(ovf_m));
    @(posedge clk);
    byp = BYP && q.size() == 0 && bpu_upd_ready_i && bu_bpu_valid_i;
    full = q.size() == D;
    popped = q.size() > 0 && bpu_upd_ready_i;
    if (popped) void'(q.pop_front());
    if (bu_bpu_valid_i && !byp) begin
      if (!full || popped) begin
        e.pc = bu_res_pc_i;
        e.target = bu_res_target_i;
        e.taken = bu_res_taken_i;
        q.push_back(e);
      end else ovf_m = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    flush_i = 0; bu_bpu_valid_i = 0; bu_res_pc_i = '0; bu_res_target_i = '0;
    bu_res_taken_i = 0; bu_pcgen_valid_i = 0; bpu_upd_ready_i = 0; pcgen_redirect_ready_i = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_i = 1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_i = 0;
    q.delete();
    ovf_m = 0;
  endtask

  task automatic rnd_fifo();
    bu_bpu_valid_i  = $urandom_range(0, 99) < 60;
    bpu_upd_ready_i = $urandom_range(0, 99) < 50;
    bu_res_pc_i     = {$urandom, $urandom};
    bu_res_target_i = {$urandom, $urandom};
    bu_res_taken_i  = $urandom_range(0, 1) == 1;
  endtask

  task automatic pulse(input logic [63:0] pc, input logic [63:0] tgt, input logic tk, input logic rdy);
    bu_bpu_valid_i = 1; bu_res_pc_i = pc; bu_res_target_i = tgt; bu_res_taken_i = tk;
    bpu_upd_ready_i = rdy;
    step();
    bu_bpu_valid_i = 0;
  endtask

  // one full redirect handshake, with pc_gen stalling for dly cycles
  task automatic redirect(input logic [63:0] pc, input logic [63:0] tgt, input logic tk, input int dly);
    logic [63:0] ex;
    ex = tk ? tgt : pc + 64'd4;
    rnd_fifo();
    bu_res_pc_i = pc; bu_res_target_i = tgt; bu_res_taken_i = tk;
    bu_pcgen_valid_i = 1; pcgen_redirect_ready_i = 0;
    step();
    for (int i = 0; i < dly; i++) begin
      chk("rd_valid_hold", 64'(pcgen_redirect_valid_o), 64'd1);
      chk("rd_pc_hold", pcgen_redirect_pc_o, ex);
      chk("ack_early", 64'(bu_pcgen_ready_o), 64'd0);
      rnd_fifo();
      step();
    end
    chk("rd_valid", 64'(pcgen_redirect_valid_o), 64'd1);
    chk("rd_pc", pcgen_redirect_pc_o, ex);
    pcgen_redirect_ready_i = 1;
    rnd_fifo();
    step();
    pcgen_redirect_ready_i = 0;
    chk("rd_valid_after_acc", 64'(pcgen_redirect_valid_o), 64'd0);
    chk("ack", 64'(bu_pcgen_ready_o), 64'd1);
    rnd_fifo();
    step();
    chk("ack_one_cycle", 64'(bu_pcgen_ready_o), 64'd0);
    chk("no_retrigger", 64'(pcgen_redirect_valid_o), 64'd0);
    bu_pcgen_valid_i = 0;
    rnd_fifo();
    step();
    chk("idle_ack", 64'(bu_pcgen_ready_o), 64'd0);
    chk("idle_valid", 64'(pcgen_redirect_valid_o), 64'd0);
  endtask

  initial begin
    do_reset();
    chk("rst_upd_valid", 64'(bpu_upd_valid_o), 64'd0);
    chk("rst_upd_pc", bpu_upd_pc_o, 64'd0);
    chk("rst_upd_target", bpu_upd_target_o, 64'd0);
    chk("rst_rd_valid", 64'(pcgen_redirect_valid_o), 64'd0);
    chk("rst_rd_pc", pcgen_redirect_pc_o, 64'd0);
    chk("rst_ack", 64'(bu_pcgen_ready_o), 64'd0);
    chk("rst_ovf", 64'(res_overflow_o), 64'd0);
    // pass-through
    pulse(64'h1000, 64'h2000, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step();
    // full FIFO with simultaneous push and pop
    for (int i = 0; i < D; i++) pulse(64'h100 + 64'(i), 64'h200, 1'b0, 1'b0);
    pulse(64'h1F0, 64'h2F0, 1'b1, 1'b1);
    bpu_upd_ready_i = 0;
    step();
    chk("full_pushpop_ovf", 64'(res_overflow_o), 64'd0);
    bpu_upd_ready_i = 1;
    for (int i = 0; i < D + 1; i++) step();
    // overflow: five pulses into four entries, then drain in order
    for (int i = 0; i < 5; i++) pulse(64'h3000 + 64'(i) * 64'h10, 64'h4000, 1'b1, 1'b0);
    step();
    chk("ovf_set", 64'(res_overflow_o), 64'd1);
    bpu_upd_ready_i = 1;
    for (int i = 0; i < D + 2; i++) step();
    chk("ovf_sticky", 64'(res_overflow_o), 64'd1);
    do_reset();
    // redirects: not taken with stall, wrap-around, taken
    redirect(64'h8000_0000, 64'h1234, 1'b0, 3);
    redirect(64'hFFFF_FFFF_FFFF_FFFC, 64'h55, 1'b0, 1);
    chk("wrap_pc", pcgen_redirect_pc_o, 64'h0);
    redirect(64'h4000, 64'hDEAD_BEE0, 1'b1, 0);
    // flush while the redirect is pending; FIFO held with ready low
    idle_inputs();
    pulse(64'hA0, 64'hB0, 1'b1, 1'b0);
    pulse(64'hA4, 64'hB4, 1'b0, 1'b0);
    bu_pcgen_valid_i = 1; bu_res_pc_i = 64'h900; bu_res_taken_i = 0;
    step();
    chk("fl_valid_before", 64'(pcgen_redirect_valid_o), 64'd1);
    flush_i = 1; bu_pcgen_valid_i = 0;
    step();
    flush_i = 0;
    chk("fl_valid_cleared", 64'(pcgen_redirect_valid_o), 64'd0);
    chk("fl_no_ack", 64'(bu_pcgen_ready_o), 64'd0);
    step();
    chk("fl_still_idle", 64'(pcgen_redirect_valid_o), 64'd0);
    chk("fl_no_ack2", 64'(bu_pcgen_ready_o), 64'd0);
    // randomized traffic with interleaved redirects
    do_reset();
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < $urandom_range(2, 8); i++) begin
        rnd_fifo();
        step();
      end
      redirect({$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, 1) == 1, $urandom_range(0, 4));
    end
    idle_inputs();
    bpu_upd_ready_i = 1;
    for (int i = 0; i < D + 2; i++) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
